// File: rtl/mux3_rr_arbiter_if.sv
// Bundle between the three data sources, the arbiter and the shared consumer.
// master drives requests and data; slave is the arbiter.
interface mux3_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [2:0]       req;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [2:0]       grant;
    logic [1:0]       selector;
    logic [WIDTH-1:0] outData;
    logic             outValid;

    modport master (
        output req, in0, in1, in2,
        input  grant, selector, outData, outValid
    );

    modport slave (
        input  req, in0, in1, in2,
        output grant, selector, outData, outValid
    );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter for three requesters sharing one 4-to-1 data mux.
// Grant/selector are registered; outData/outValid follow one cycle later.
module mux3_rr_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic               clk,
    input logic               rst_n,
    mux3_rr_arbiter_if.slave  bus
);
    localparam logic [1:0] SelIdle  = 2'b11;
    localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       hold_q, hold_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [1:0] cand0, cand1, cand2, pick;
    logic       found;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        case (i)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Search order: lastOwner+1, lastOwner+2, lastOwner.
    always_comb begin
        cand0 = next_idx(last_q);
        cand1 = next_idx(cand0);
        cand2 = last_q;
        found = |bus.req;
        if (bus.req[cand0])      pick = cand0;
        else if (bus.req[cand1]) pick = cand1;
        else                     pick = cand2;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StOwn;
                    grant_d = 3'b001 << pick;
                    sel_d   = pick;
                    last_d  = pick;
                    hold_d  = '0;
                end
            end
            StOwn: begin
                if (bus.req[last_q] && (hold_q < HoldLast)) begin
                    hold_d = hold_q + 4'd1;
                end else if (found) begin
                    // Release or expiry with a requester pending: hand over with no idle gap.
                    grant_d = 3'b001 << pick;
                    sel_d   = pick;
                    last_d  = pick;
                    hold_d  = '0;
                end else begin
                    state_d = StIdle;
                    grant_d = 3'b000;
                    sel_d   = SelIdle;
                    hold_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath uses the registered selector, so data lags grant by one cycle.
    always_comb begin
        case (sel_q)
            2'd0:    data_d = bus.in0;
            2'd1:    data_d = bus.in1;
            2'd2:    data_d = bus.in2;
            default: data_d = '0;
        endcase
        valid_d = (sel_q != SelIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 3'b000;
            sel_q   <= SelIdle;
            last_q  <= 2'd2;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.selector = sel_q;
    assign bus.outData  = data_q;
    assign bus.outValid = valid_q;
endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed bench for mux3_rr_arbiter: expected outputs go into a scoreboard
// queue as each step is driven and are popped and compared after the edge.
module tb_mux3_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    mux3_rr_arbiter_if #(.WIDTH(8)) bus ();

    mux3_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [2:0] grant;
        logic [1:0] sel;
        logic [7:0] data;
        logic       valid;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [7:0] din [3];

    task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] g, input logic [1:0] s,
                        input logic [7:0] d, input logic v);
        exp_t e;
        e.tag = tag; e.grant = g; e.sel = s; e.data = d; e.valid = v;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".grant"},    {5'b0, bus.grant},    {5'b0, e.grant});
            cmp({e.tag, ".selector"}, {6'b0, bus.selector}, {6'b0, e.sel});
            cmp({e.tag, ".outData"},  bus.outData,          e.data);
            cmp({e.tag, ".outValid"}, {7'b0, bus.outValid}, {7'b0, e.valid});
        end
    endtask

    // Drive req, expect the given outputs after the next rising edge.
    task automatic step(input string tag, input logic [2:0] r, input logic [2:0] g,
                        input logic [1:0] s, input logic [7:0] d, input logic v);
        bus.req = r;
        push(tag, g, s, d, v);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic check_now(input string tag, input logic [2:0] g, input logic [1:0] s,
                             input logic [7:0] d, input logic v);
        push(tag, g, s, d, v);
        pop_check();
    endtask

    task automatic do_reset();
        bus.req = 3'b000;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
    endtask

    initial begin
        din[0] = 8'd5; din[1] = 8'd10; din[2] = 8'd15;
        bus.in0 = din[0];
        bus.in1 = din[1];
        bus.in2 = din[2];
        bus.req = 3'b111;
        rst_n   = 1'b0;

        // Reset held with all requests high.
        #12;
        check_now("rst_hold", 3'b000, 2'b11, 8'd0, 1'b0);
        step("rst_edge", 3'b111, 3'b000, 2'b11, 8'd0, 1'b0);
        rst_n = 1'b1;
        step("idle", 3'b000, 3'b000, 2'b11, 8'd0, 1'b0);

        // Single requester, including a hold expiry with no gap.
        step("single1", 3'b001, 3'b001, 2'b00, 8'd0, 1'b0);
        for (int i = 0; i < 6; i++) step("single", 3'b001, 3'b001, 2'b00, 8'd5, 1'b1);

        // Full contention from reset: four cycles per owner, data lags by one.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            int o;
            int p;
            o = (i / 4) % 3;
            p = (i == 0) ? 0 : ((i - 1) / 4) % 3;
            step("contend", 3'b111, 3'(1 << o), 2'(o), (i == 0) ? 8'd0 : din[p], i != 0);
        end

        // Early release of owner 0, then idle.
        do_reset();
        step("early1", 3'b011, 3'b001, 2'b00, 8'd0,  1'b0);
        step("early2", 3'b011, 3'b001, 2'b00, 8'd5,  1'b1);
        step("early3", 3'b010, 3'b010, 2'b01, 8'd5,  1'b1);
        step("early4", 3'b010, 3'b010, 2'b01, 8'd10, 1'b1);
        step("rel1",   3'b000, 3'b000, 2'b11, 8'd10, 1'b1);
        step("rel2",   3'b000, 3'b000, 2'b11, 8'd0,  1'b0);

        // Fairness after idle: last owner 1, so order is 2, 0, 1.
        step("fair_a", 3'b111, 3'b100, 2'b10, 8'd0,  1'b0);
        step("fair_b", 3'b111, 3'b100, 2'b10, 8'd15, 1'b1);
        step("fair_c", 3'b111, 3'b100, 2'b10, 8'd15, 1'b1);
        step("fair_d", 3'b111, 3'b100, 2'b10, 8'd15, 1'b1);
        step("fair_e", 3'b111, 3'b001, 2'b00, 8'd15, 1'b1);
        step("fair_f", 3'b111, 3'b001, 2'b00, 8'd5,  1'b1);
        step("fair_g", 3'b111, 3'b001, 2'b00, 8'd5,  1'b1);
        step("fair_h", 3'b111, 3'b001, 2'b00, 8'd5,  1'b1);
        step("fair_i", 3'b111, 3'b010, 2'b01, 8'd5,  1'b1);
        step("fair_j", 3'b111, 3'b010, 2'b01, 8'd10, 1'b1);
        step("fair_k", 3'b111, 3'b010, 2'b01, 8'd10, 1'b1);
        step("fair_l", 3'b111, 3'b010, 2'b01, 8'd10, 1'b1);
        step("fair_m", 3'b111, 3'b100, 2'b10, 8'd10, 1'b1);
        step("fair_n", 3'b111, 3'b100, 2'b10, 8'd15, 1'b1);

        // Asynchronous reset mid-grant of owner 2, no clock edge needed.
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_rst", 3'b000, 2'b11, 8'd0, 1'b0);
        step("rst_mid", 3'b111, 3'b000, 2'b11, 8'd0, 1'b0);
        rst_n = 1'b1;
        step("post_rst1", 3'b111, 3'b001, 2'b00, 8'd0, 1'b0);
        step("post_rst2", 3'b111, 3'b001, 2'b00, 8'd5, 1'b1);

        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
